// File: rtl/aes_mode_pkg.sv
// Shared definitions for the AES stream mode controller: block width default,
// cipher mode encodings and controller state encoding.
package aes_mode_pkg;

  localparam int DATA_W_DEF = 128;

  typedef enum logic [2:0] {
    MODE_ECB = 3'd0,
    MODE_CBC = 3'd1,
    MODE_CFB = 3'd2,
    MODE_OFB = 3'd3,
    MODE_CTR = 3'd4
  } mode_e;

  // Any mode code above this one is rejected at start.
  localparam logic [2:0] MODE_MAX = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_IN   = 3'd2,
    ST_CORE_GO   = 3'd3,
    ST_CORE_WAIT = 3'd4,
    ST_OUT       = 3'd5,
    ST_FIN       = 3'd6
  } state_e;

endpackage

// File: rtl/aes_mode_datapath.sv
// Combinational pre-XOR, post-XOR and feedback selection for the five block
// cipher modes; the controller owns every register.
module aes_mode_datapath
  import aes_mode_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTR_W  = 32
) (
  input  logic [2:0]        mode_i,
  input  logic              encrypt_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] fb_i,
  input  logic [DATA_W-1:0] core_out_i,
  output logic [DATA_W-1:0] core_in_o,
  output logic              core_decrypt_o,
  output logic [DATA_W-1:0] out_o,
  output logic [DATA_W-1:0] fb_next_o
);

  // Only the low CTR_W bits of the counter block roll over; the rest is a nonce.
  localparam logic [DATA_W-1:0] CTR_MASK = {DATA_W{1'b1}} >> (DATA_W - CTR_W);

  logic [DATA_W-1:0] ctr_next;
  logic [DATA_W-1:0] stream_out;

  assign ctr_next   = (fb_i & ~CTR_MASK) | ((fb_i + DATA_W'(1)) & CTR_MASK);
  assign stream_out = data_i ^ core_out_i;

  always_comb begin
    core_in_o      = data_i;
    core_decrypt_o = 1'b0;
    out_o          = core_out_i;
    fb_next_o      = fb_i;
    case (mode_i)
      MODE_ECB: begin
        core_decrypt_o = ~encrypt_i;
      end
      MODE_CBC: begin
        core_decrypt_o = ~encrypt_i;
        if (encrypt_i) begin
          core_in_o = data_i ^ fb_i;
          fb_next_o = core_out_i;
        end else begin
          out_o     = core_out_i ^ fb_i;
          fb_next_o = data_i;
        end
      end
      MODE_CFB: begin
        core_in_o = fb_i;
        out_o     = stream_out;
        fb_next_o = encrypt_i ? stream_out : data_i;
      end
      MODE_OFB: begin
        core_in_o = fb_i;
        out_o     = stream_out;
        fb_next_o = core_out_i;
      end
      MODE_CTR: begin
        core_in_o = fb_i;
        out_o     = stream_out;
        fb_next_o = ctr_next;
      end
      default: begin
        core_decrypt_o = ~encrypt_i;
      end
    endcase
  end

endmodule

// File: rtl/aes_stream_mode_ctrl.sv
// Block cipher mode sequencer: streams blocks through an external AES core in
// ECB/CBC/CFB/OFB/CTR with exactly one block in flight.
module aes_stream_mode_ctrl
  import aes_mode_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTR_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        mode,
  input  logic              encrypt,
  input  logic [DATA_W-1:0] iv,
  input  logic [CNT_W-1:0]  num_blocks,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              core_start,
  output logic              core_decrypt,
  output logic [DATA_W-1:0] core_in,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_e            state_q, state_d;
  logic [2:0]        mode_q, mode_d;
  logic              enc_q, enc_d;
  logic [DATA_W-1:0] fb_q, fb_d;
  logic [DATA_W-1:0] fb_pend_q, fb_pend_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  logic              error_q, error_d;

  logic [DATA_W-1:0] dp_out;
  logic [DATA_W-1:0] dp_fb_next;

  aes_mode_datapath #(
    .DATA_W (DATA_W),
    .CTR_W  (CTR_W)
  ) u_datapath (
    .mode_i         (mode_q),
    .encrypt_i      (enc_q),
    .data_i         (din_q),
    .fb_i           (fb_q),
    .core_out_i     (core_out),
    .core_in_o      (core_in),
    .core_decrypt_o (core_decrypt),
    .out_o          (dp_out),
    .fb_next_o      (dp_fb_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= 3'd0;
      enc_q     <= 1'b0;
      fb_q      <= '0;
      fb_pend_q <= '0;
      din_q     <= '0;
      out_q     <= '0;
      remain_q  <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      enc_q     <= enc_d;
      fb_q      <= fb_d;
      fb_pend_q <= fb_pend_d;
      din_q     <= din_d;
      out_q     <= out_d;
      remain_q  <= remain_d;
      error_q   <= error_d;
    end
  end

  // The feedback value is computed while core_out is valid but only committed
  // once the consumer accepts the block, so an abort leaves the chain intact.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    enc_d     = enc_q;
    fb_d      = fb_q;
    fb_pend_d = fb_pend_q;
    din_d     = din_q;
    out_d     = out_q;
    remain_d  = remain_q;
    error_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (mode <= MODE_MAX) state_d = ST_LOAD;
          else                  error_d = 1'b1;
        end
      end
      ST_LOAD: begin
        mode_d   = mode;
        enc_d    = encrypt;
        fb_d     = iv;
        remain_d = num_blocks;
        state_d  = (num_blocks == '0) ? ST_FIN : ST_WAIT_IN;
      end
      ST_WAIT_IN: begin
        if (in_valid) begin
          din_d   = in_data;
          state_d = ST_CORE_GO;
        end
      end
      ST_CORE_GO: begin
        state_d = ST_CORE_WAIT;
      end
      ST_CORE_WAIT: begin
        if (core_done) begin
          out_d     = dp_out;
          fb_pend_d = dp_fb_next;
          state_d   = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          fb_d     = fb_pend_q;
          remain_d = remain_q - CNT_W'(1);
          state_d  = (remain_q == CNT_W'(1)) ? ST_FIN : ST_WAIT_IN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  assign in_ready   = (state_q == ST_WAIT_IN);
  assign core_start = (state_q == ST_CORE_GO);
  assign out_valid  = (state_q == ST_OUT);
  assign out_data   = out_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FIN);
  assign error      = error_q;

endmodule

// File: doc/aes_stream_mode_ctrl.md
AES_STREAM_MODE_CTRL -- requirements
Module: aes_stream_mode_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning block and IV width.
REQ-002 SHALL have parameter CTR_W, default 32, meaning width of the low counter field incremented in CTR mode (1..DATA_W).
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of the block-count input.
REQ-004 SHALL have one clock and asynchronous active-low reset: clk in 1 rising-edge clock; reset_n in 1 async active-low reset.
REQ-005 SHALL have ports start in 1 (begin message), abort in 1 (sync cancel), mode in 3 (0 ECB, 1 CBC, 2 CFB, 3 OFB, 4 CTR), encrypt in 1 (1 = encrypt), iv in DATA_W (IV or initial counter), num_blocks in CNT_W.
REQ-006 SHALL have ports in_valid in 1, in_ready out 1, in_data in DATA_W (plaintext or ciphertext stream).
REQ-007 SHALL have ports core_start out 1, core_decrypt out 1, core_in out DATA_W, core_done in 1, core_out in DATA_W (AES core interface).
REQ-008 SHALL have ports out_valid out 1, out_ready in 1, out_data out DATA_W, busy out 1, done out 1, error out 1.

Function
REQ-009 SHALL implement states IDLE, LOAD, WAIT_IN, CORE_GO, CORE_WAIT, OUT, FIN.
REQ-010 IDLE: on start with mode<=4 -> LOAD; on start with mode>=5 -> error high one cycle, remain IDLE.
REQ-011 LOAD: latch mode, encrypt, iv into the fb/ctr register, num_blocks into the remaining counter; -> FIN if num_blocks==0, else WAIT_IN.
REQ-012 WAIT_IN: in_ready=1; on in_valid, latch in_data -> CORE_GO.
REQ-013 CORE_GO: core_start=1 for exactly one cycle; core_in and core_decrypt valid this cycle -> CORE_WAIT.
REQ-014 CORE_WAIT: on core_done, latch result per REQ-016 into out_data register -> OUT.
REQ-015 OUT: out_valid=1, out_data stable until out_ready; on handshake, update fb/ctr, decrement remaining; -> WAIT_IN if remaining after decrement >0, else FIN.
REQ-016 Datapath (d = latched input, F = fb reg, E = core_out): ECB core_in=d, out=E; CBC enc core_in=d^F, out=E, F<=E; CBC dec core_in=d, out=E^F, F<=d; CFB core_in=F, out=d^E, F<=(enc ? out : d); OFB core_in=F, out=d^E, F<=E; CTR core_in=F, out=d^E, F[CTR_W-1:0]<=F[CTR_W-1:0]+1 mod 2^CTR_W, upper bits unchanged.
REQ-017 core_decrypt SHALL be ~encrypt in ECB/CBC and 0 in CFB/OFB/CTR.
REQ-018 FIN: done=1 for exactly one cycle -> IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 start while busy SHALL be ignored; mode/encrypt/iv changes after LOAD SHALL have no effect.
REQ-021 abort in any non-IDLE state SHALL return to IDLE next cycle, no done, no error, out_valid dropped; a core_done arriving later in IDLE SHALL be ignored.
REQ-022 Latency: in handshake to core_start = 1 cycle; core_done to out_valid = 1 cycle; out handshake to in_ready = 1 cycle.
REQ-023 in_ready and out_valid SHALL never be high simultaneously (one block in flight).

Reset
REQ-024 reset_n low SHALL asynchronously force IDLE and clear all registers; in_ready, core_start, out_valid, out_data, busy, done, error SHALL be 0, including when asserted mid-message.

Structure
REQ-025 Mode encodings, state encoding and DATA_W default SHALL live in shared package aes_mode_pkg.
REQ-026 The mode pre/post XOR and feedback-select logic SHALL be one combinational sub-module aes_mode_datapath; FSM and registers stay in the top.

Verification (bench core stub: core_out = core_in, core_done 4 cycles after core_start)
REQ-027 ECB, num_blocks=2, in 0x11..11 then 0x22..22 -> out 0x11..11, 0x22..22, core_decrypt=0, one done.
REQ-028 CBC enc, iv=0x0F..0F, in 0xF0..F0 then 0x00..00 -> out 0xFF..FF then 0xFF..FF.
REQ-029 CTR, CTR_W=32, iv=0x00..00_FFFFFFFF, num_blocks=2, in all-zero -> core_in 0x00..00_FFFFFFFF then 0x00..00_00000000 (upper 96 bits unchanged).
REQ-030 out_ready held low 10 cycles in OUT -> out_data stable, in_ready 0, no second core_start.
REQ-031 num_blocks=0 -> done 2 cycles after start, no core_start; start with mode=6 -> error 1 cycle, busy 0.
REQ-032 abort in CORE_WAIT, then late core_done -> IDLE, no out_valid, no done; reset_n low mid-OUT -> all outputs 0 immediately.
